tx_frame_asm: RTL and testbench
===============================

# tx_frame_asm

Transmit-side frame assembler, the counterpart of the receiver's data separation and cyclic-prefix removal stages. It prepends the time-domain preamble, read from an external synchronous ROM, to a burst of IFFT-output OFDM symbols. It inserts a cyclic prefix on each symbol and emits one continuous 12-bit complex sample stream toward the DAC interface. Ping-pong symbol buffering lets symbol k+1 load while symbol k is being played out.

## Interface
Parameters:
- NFFT, 64: samples per OFDM symbol body (power of two).
- NCP, 16: cyclic-prefix length; NCP < NFFT.
- NPRE, 160: preamble length in samples.
- NSYM_W, 8: width of the symbol-count port.

Ports:
- clk  in  1  working clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  frame request pulse; sampled in IDLE only.
- num_sym  in  NSYM_W  number of data symbols (signal + payload) in the frame; sampled with start.
- busy  out  1  high from the cycle after an accepted start through the cycle after do_eof.
- pre_addr  out  clog2(NPRE)  preamble ROM address.
- pre_re, pre_im  in  12 signed  ROM data; 1-cycle read latency.
- di_re, di_im  in  12 signed  IFFT output samples, natural order.
- di_vld  in  1  input sample valid.
- di_rdy  out  1  a sample is accepted when di_vld && di_rdy.
- do_re, do_im  out  12 signed  assembled output stream.
- do_vld  out  1  output sample valid.
- do_sof  out  1  with the first preamble sample.
- do_eof  out  1  with the last sample of the last symbol.
- underrun  out  1  one-cycle pulse when playout stalls for a missing symbol.

## Operation
- States: IDLE, PRE, SYM, DONE.
- IDLE: start && num_sym != 0 → PRE. Latch num_sym. Clear both buffers and the load and play counters.
- start with num_sym == 0 is ignored. start outside IDLE is ignored.
- PRE: pre_addr counts 0..NPRE-1, one address per cycle. Each ROM word is output one cycle later, unmodified.
- Loading: two NFFT-deep buffers, A and B, filled alternately starting with A.
- di_rdy = busy && (a buffer is free) && (symbols loaded < num_sym).
- Each buffer is written at indices 0..NFFT-1. A buffer is marked full on its NFFT-th accepted sample.
- Samples presented while di_rdy is low are dropped.
- SYM: play the current full buffer as indices NFFT-NCP..NFFT-1 (CP), then 0..NFFT-1 (body). That is NFFT+NCP samples per symbol.
- The buffer is freed after its last body sample is read. Playout then switches to the other buffer.
- After num_sym symbols have played → DONE (one cycle, busy still high) → IDLE.
- Underrun: if the next buffer is not full when needed, do_vld drops and underrun pulses once.
  - Playout resumes, starting with that symbol's CP, on the cycle after the buffer becomes full plus read latency.
  - The same rule applies to symbol 0 at the end of the preamble.
- Data path is a pure pass-through: no scaling, rounding or saturation.
- Per frame, the count of do_vld cycles is exactly NPRE + num_sym*(NFFT+NCP).

## Timing
- Reset values: do_re/do_im = 0; do_vld, do_sof, do_eof, underrun, busy, di_rdy = 0; pre_addr = 0; state IDLE.
- Asynchronous reset mid-frame aborts immediately. Buffers are invalidated; the next start produces a clean frame.
- start is sampled at cycle t. At t+1: busy = 1, pre_addr = 0, di_rdy may rise. At t+2: do_vld = do_sof = 1 with ROM word 0.
- Preamble output is contiguous, cycles t+2..t+NPRE+1.
- If buffer A is full by cycle t+NPRE, the first CP sample appears at t+NPRE+2 with no gap.
- The buffer read path has 1-cycle latency. Read addresses are pipelined so that back-to-back symbols are gapless.
- do_sof and do_eof are asserted only while do_vld is high. For NPRE ≥ 1 they never coincide.
- A buffer freed in cycle c may accept input in cycle c+1.
- Simultaneous write of the last sample into one buffer and read of the last sample from the other buffer is legal. The symbol that just became full is played next without a gap.

## Test plan
- Reset: hold rst for 5 cycles. All outputs are 0. di_vld pulsed during reset is ignored.
- Single symbol: num_sym=1, ROM word i = (i, -i), input ramp di_re=k, di_im=-k fed during the preamble.
  - Expect 240 valid samples: 160 preamble, then 48..63, then 0..63.
  - do_sof on sample 0; do_eof on sample 239; busy falls 2 cycles after do_eof.
- Back-to-back: num_sym=3, di_vld held high.
  - Expect 400 contiguous valid samples.
  - di_rdy drops after 128 accepted samples and rises the cycle after buffer A's last body read.
- Underrun: num_sym=2, symbol 1 input delayed 100 cycles past symbol 0's end.
  - Expect a gap, a single underrun pulse, and resumption at CP sample 48.
  - Total valid count stays 320.
- Ignored requests: start with num_sym=0 produces no busy. start pulsed mid-frame does not alter the output sequence or count.
- Reset mid-symbol: assert rst during the body of symbol 0. Outputs go 0 within the reset cycle. A following start with num_sym=1 yields the exact stream of the single-symbol scenario.

Source files
------------

// File: rtl/tx_frame_asm.sv
// Transmit frame assembler: preamble from external ROM, then cyclic-prefixed
// OFDM symbols played from ping-pong buffers as one contiguous sample stream.
module tx_frame_asm #(
  parameter int NFFT   = 64,
  parameter int NCP    = 16,
  parameter int NPRE   = 160,
  parameter int NSYM_W = 8,
  localparam int PAW   = $clog2(NPRE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NSYM_W-1:0]   num_sym,
  output logic                busy,
  output logic [PAW-1:0]      pre_addr,
  input  logic signed [11:0]  pre_re,
  input  logic signed [11:0]  pre_im,
  input  logic signed [11:0]  di_re,
  input  logic signed [11:0]  di_im,
  input  logic                di_vld,
  output logic                di_rdy,
  output logic signed [11:0]  do_re,
  output logic signed [11:0]  do_im,
  output logic                do_vld,
  output logic                do_sof,
  output logic                do_eof,
  output logic                underrun
);

  // state | meaning
  // IDLE  | waiting for start with non-zero num_sym
  // PRE   | stepping preamble ROM addresses
  // SYM   | playing CP + body of each loaded symbol
  // DONE  | one trailing busy cycle before IDLE

  localparam int AW = $clog2(NFFT);
  localparam int PW = $clog2(NFFT + NCP);

  typedef enum logic [1:0] {IDLE, PRE, SYM, DONE} state_t;

  state_t            state;
  logic [NSYM_W-1:0] num_q, load_cnt, sym_cnt;
  logic [1:0]        full;
  logic              wbuf, cur, stall_q;
  logic [AW-1:0]     widx, rd_addr;
  logic [PW-1:0]     play_idx;
  logic [23:0]       mem [2*NFFT];
  logic [23:0]       buf_q;
  logic              pre_sel, buf_vld, sof_q, eof_q, und_q, busy_q;
  logic              accept, issue, last_rd;

  assign di_rdy  = busy_q && !full[wbuf] && (load_cnt < num_q);
  assign accept  = di_vld && di_rdy;
  assign issue   = (state == SYM) && (sym_cnt != num_q) && full[cur];
  assign last_rd = (play_idx == PW'(NFFT + NCP - 1));
  // First NCP play slots map onto the tail of the body.
  assign rd_addr = (play_idx < PW'(NCP)) ? AW'(play_idx) + AW'(NFFT - NCP)
                                         : AW'(play_idx - PW'(NCP));

  always_ff @(posedge clk) begin
    if (accept) mem[{wbuf, widx}] <= {di_re, di_im};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      num_q    <= '0;
      load_cnt <= '0;
      sym_cnt  <= '0;
      full     <= '0;
      wbuf     <= 1'b0;
      cur      <= 1'b0;
      stall_q  <= 1'b0;
      widx     <= '0;
      play_idx <= '0;
      pre_addr <= '0;
      buf_q    <= '0;
      pre_sel  <= 1'b0;
      buf_vld  <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      und_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      pre_sel <= 1'b0;
      buf_vld <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      und_q   <= 1'b0;

      if (accept) begin
        widx <= widx + AW'(1);
        if (widx == AW'(NFFT - 1)) begin
          full[wbuf] <= 1'b1;
          wbuf       <= ~wbuf;
          load_cnt   <= load_cnt + NSYM_W'(1);
        end
      end

      if (issue) begin
        buf_q   <= mem[{cur, rd_addr}];
        buf_vld <= 1'b1;
        stall_q <= 1'b0;
        if (last_rd) begin
          play_idx  <= '0;
          full[cur] <= 1'b0;
          cur       <= ~cur;
          sym_cnt   <= sym_cnt + NSYM_W'(1);
          eof_q     <= (sym_cnt == num_q - NSYM_W'(1));
        end else begin
          play_idx <= play_idx + PW'(1);
        end
      end

      case (state)
        IDLE: begin
          if (start && num_sym != '0) begin
            state    <= PRE;
            busy_q   <= 1'b1;
            num_q    <= num_sym;
            pre_addr <= '0;
            full     <= '0;
            wbuf     <= 1'b0;
            cur      <= 1'b0;
            widx     <= '0;
            load_cnt <= '0;
            sym_cnt  <= '0;
            play_idx <= '0;
            stall_q  <= 1'b0;
          end
        end
        PRE: begin
          pre_sel <= 1'b1;
          sof_q   <= (pre_addr == '0);
          if (pre_addr == PAW'(NPRE - 1)) begin
            pre_addr <= '0;
            state    <= SYM;
          end else begin
            pre_addr <= pre_addr + PAW'(1);
          end
        end
        SYM: begin
          if (sym_cnt == num_q) begin
            state <= DONE;
          end else if (!full[cur]) begin
            und_q   <= !stall_q;
            stall_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ROM data arrives one cycle after its address, so it is passed straight through.
  assign do_re    = pre_sel ? pre_re : buf_q[23:12];
  assign do_im    = pre_sel ? pre_im : buf_q[11:0];
  assign do_vld   = pre_sel | buf_vld;
  assign do_sof   = sof_q;
  assign do_eof   = eof_q;
  assign underrun = und_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_tx_frame_asm.sv
// Scoreboard bench for tx_frame_asm: expected streams queued at stimulus time,
// popped and compared by an independent output monitor.
module tb_tx_frame_asm;

  localparam int NFFT = 64, NCP = 16, NPRE = 160, NSYM_W = 8;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, di_vld = 1'b0;
  logic [NSYM_W-1:0] num_sym = '0;
  logic busy, di_rdy, do_vld, do_sof, do_eof, underrun;
  logic [7:0] pre_addr;
  logic signed [11:0] pre_re, pre_im, di_re = '0, di_im = '0, do_re, do_im;

  tx_frame_asm #(.NFFT(NFFT), .NCP(NCP), .NPRE(NPRE), .NSYM_W(NSYM_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_sym(num_sym), .busy(busy),
    .pre_addr(pre_addr), .pre_re(pre_re), .pre_im(pre_im),
    .di_re(di_re), .di_im(di_im), .di_vld(di_vld), .di_rdy(di_rdy),
    .do_re(do_re), .do_im(do_im), .do_vld(do_vld), .do_sof(do_sof),
    .do_eof(do_eof), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Preamble ROM: word i = (i, -i), one-cycle read latency
  always @(posedge clk) begin
    pre_re <= 12'(int'(pre_addr));
    pre_im <= 12'(-int'(pre_addr));
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;
  logic [25:0] sb[$];
  int vld_cnt, und_cnt, first_cyc, last_cyc, eof_cyc, busy_fall, s239_cyc, s240_cyc;
  int rdy_fall1, rdy_rise, acc_cnt, acc128_cyc, last_acc_cyc, ts;
  logic busy_prev = 1'b0, rdy_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic clear_stats();
    vld_cnt = 0; und_cnt = 0; first_cyc = -1; last_cyc = -1; eof_cyc = -1;
    busy_fall = -1; s239_cyc = -1; s240_cyc = -1; rdy_fall1 = -1; rdy_rise = -1;
    acc_cnt = 0; acc128_cyc = -1; last_acc_cyc = -1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (underrun) und_cnt++;
      if (do_vld) begin
        if (vld_cnt == 0) first_cyc = cyc;
        if (vld_cnt == 239) s239_cyc = cyc;
        if (vld_cnt == 240) s240_cyc = cyc;
        last_cyc = cyc;
        vld_cnt++;
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_sample: got %h expected none", {do_re, do_im, do_sof, do_eof});
        end else begin
          check("stream", {6'd0, do_re, do_im, do_sof, do_eof}, {6'd0, sb.pop_front()});
        end
      end else if (do_sof || do_eof) begin
        check("flag_without_vld", {30'd0, do_sof, do_eof}, 32'd0);
      end
      if (do_eof) eof_cyc = cyc;
      if (busy_prev && !busy) busy_fall = cyc;
      if (rdy_prev && !di_rdy && rdy_fall1 < 0) rdy_fall1 = cyc;
      if (!rdy_prev && di_rdy) rdy_rise = cyc;
      busy_prev = busy;
      rdy_prev  = di_rdy;
    end
  end

  task automatic push_frame(input int nsym);
    for (int i = 0; i < NPRE; i++)
      sb.push_back({12'(i), 12'(-i), (i == 0), 1'b0});
    for (int s = 0; s < nsym; s++)
      for (int j = 0; j < NFFT + NCP; j++) begin
        int v;
        v = s * NFFT + ((j < NCP) ? (NFFT - NCP + j) : (j - NCP));
        sb.push_back({12'(v), 12'(-v), 1'b0, (s == nsym - 1 && j == NFFT + NCP - 1)});
      end
  endtask

  task automatic do_start(input int n);
    @(negedge clk);
    start = 1'b1; num_sym = NSYM_W'(n); ts = cyc;
    @(negedge clk);
    start = 1'b0;
    check("busy_t1", {31'd0, busy}, 32'd1);
    check("pre_addr_t1", {24'd0, pre_addr}, 32'd0);
  endtask

  task automatic feed(input int n, input int base);
    int k = base, acc = 0, g = 0;
    while (acc < n && g < 5000) begin
      @(negedge clk);
      g++;
      di_vld = 1'b1; di_re = 12'(k); di_im = 12'(-k);
      if (di_rdy) begin
        acc++; k++; acc_cnt++; last_acc_cyc = cyc;
        if (acc_cnt == 128) acc128_cyc = cyc;
      end
    end
    check("feed_timeout", acc, n);
    @(negedge clk);
    di_vld = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (busy && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check("frame_done_timeout", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_vld(input int n);
    int g = 0;
    while (vld_cnt < n && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check("wait_vld_timeout", {31'd0, (vld_cnt >= n)}, 32'd1);
  endtask

  task automatic run_single();
    clear_stats();
    push_frame(1);
    do_start(1);
    fork
      feed(64, 0);
      wait_done();
    join
    check("single_count", vld_cnt, 240);
    check("single_sof_time", first_cyc - ts, 2);
    check("single_busy_after_eof", busy_fall - eof_cyc, 2);
    check("single_underrun", und_cnt, 0);
    check("single_sb_empty", sb.size(), 0);
  endtask

  initial begin
    clear_stats();
    // Reset held 5 cycles with a stray di_vld pulse
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      di_vld = (i == 2);
      check("reset_outputs",
            {6'd0, do_vld, do_sof, do_eof, underrun, busy, di_rdy, pre_addr, do_re},
            32'd0);
      check("reset_do_im", {20'd0, do_im}, 32'd0);
    end
    di_vld = 1'b0;
    rst = 1'b0;

    run_single();

    // Back-to-back, input always offered
    clear_stats();
    push_frame(3);
    do_start(3);
    fork
      feed(192, 0);
      wait_done();
    join
    check("b2b_count", vld_cnt, 400);
    check("b2b_contiguous", last_cyc - first_cyc + 1, 400);
    check("b2b_rdy_drop", rdy_fall1, acc128_cyc + 1);
    check("b2b_rdy_rise", rdy_rise, s239_cyc);
    check("b2b_underrun", und_cnt, 0);
    check("b2b_sb_empty", sb.size(), 0);

    // Underrun: second symbol arrives late
    clear_stats();
    push_frame(2);
    do_start(2);
    fork
      feed(64, 0);
      begin
        wait_vld(240);
        repeat (100) @(negedge clk);
        feed(64, 64);
      end
    join
    wait_done();
    check("und_pulses", und_cnt, 1);
    check("und_count", vld_cnt, 320);
    check("und_gap", {31'd0, (last_cyc - first_cyc + 1 > 320)}, 32'd1);
    check("und_resume_time", s240_cyc, last_acc_cyc + 2);
    check("und_sb_empty", sb.size(), 0);

    // start with num_sym == 0 is ignored
    clear_stats();
    @(negedge clk);
    start = 1'b1; num_sym = '0;
    @(negedge clk);
    start = 1'b0;
    begin
      logic seen = 1'b0;
      repeat (5) begin
        @(negedge clk);
        seen = seen | busy | do_vld;
      end
      check("zero_sym_ignored", {31'd0, seen}, 32'd0);
    end

    // start pulsed mid-frame is ignored
    clear_stats();
    push_frame(1);
    do_start(1);
    fork
      feed(64, 0);
      begin
        repeat (50) @(negedge clk);
        start = 1'b1; num_sym = NSYM_W'(5);
        @(negedge clk);
        start = 1'b0;
      end
      wait_done();
    join
    check("midstart_count", vld_cnt, 240);
    check("midstart_sb_empty", sb.size(), 0);

    // Reset during symbol-0 body, then a clean frame
    clear_stats();
    push_frame(1);
    do_start(1);
    fork
      feed(64, 0);
      begin
        wait_vld(200);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_outputs",
              {8'd0, do_vld, do_sof, do_eof, underrun, busy, di_rdy, do_re, 6'd0}, 32'd0);
        check("midrst_do_im", {20'd0, do_im}, 32'd0);
      end
    join
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_single();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
